// File: rtl/switch_mem_cfg_regs_if.sv
// switch_mem_cfg_regs_if: mem_* request/acknowledge bus between memory driver and config registers
interface switch_mem_cfg_regs_if;
  logic       mem_sel_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic       mem_wr_rd_s;
  logic [7:0] mem_rd_data;
  logic       mem_ack;
  modport master (output mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s, input mem_rd_data, mem_ack);
  modport slave (input mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s, output mem_rd_data, mem_ack);
endinterface

// File: rtl/switch_mem_cfg_regs.sv
// switch_mem_cfg_regs: port address/enable config registers behind mem_* handshake; MEM_CFG_LOCK_EN adds a write lock at 8'h12
module switch_mem_cfg_regs #(
  parameter int         NUM_PORTS = 4,
  parameter int         ACK_DLY   = 1,
  parameter logic [7:0] ID_VAL    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  switch_mem_cfg_regs_if.slave   bus,
  output logic [8*NUM_PORTS-1:0] port_addr,
  output logic [NUM_PORTS-1:0]   port_en
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] addr_q, data_q, rd_val;
  logic       wr_q, locked;
`ifdef MEM_CFG_LOCK_EN
  logic       lock;
  assign locked = lock && addr_q <= 8'h10;
`else
  assign locked = 1'b0;
`endif
  // state and wait counter; the request is captured only when accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
    if (state == IDLE && bus.mem_sel_en) begin
      addr_q <= bus.mem_addr;
      data_q <= bus.mem_wr_data;
      wr_q   <= bus.mem_wr_rd_s;
    end
  end
  // next state: a strobe dropped while waiting aborts the access
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (bus.mem_sel_en) begin
        cnt_n   = 4'(ACK_DLY);
        state_n = (ACK_DLY == 0) ? ACK : WAIT;
      end
      WAIT: begin
        cnt_n   = cnt - 4'd1;
        state_n = !bus.mem_sel_en ? IDLE : (cnt == 4'd1) ? ACK : WAIT;
      end
      ACK:     state_n = RELEASE;
      default: state_n = bus.mem_sel_en ? RELEASE : IDLE;
    endcase
  end
  // read decode from the pre-commit register values
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++)
      if (addr_q == 8'(i)) rd_val = port_addr[8*i +: 8];
    if (addr_q == 8'h10) rd_val = 8'(port_en);
    if (addr_q == 8'h11) rd_val = ID_VAL;
`ifdef MEM_CFG_LOCK_EN
    if (addr_q == 8'h12) rd_val = {7'd0, lock};
`endif
  end
  assign bus.mem_ack     = state == ACK;
  assign bus.mem_rd_data = (state == ACK && !wr_q) ? rd_val : 8'h00;
  // writes commit on the ack edge unless the lock protects the target
  always_ff @(posedge clk) begin
    if (rst) begin
      port_addr <= '0;
      port_en   <= '0;
    end else if (state == ACK && wr_q && !locked) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (addr_q == 8'(i)) port_addr[8*i +: 8] <= data_q;
      if (addr_q == 8'h10) port_en <= data_q[NUM_PORTS-1:0];
    end
  end
`ifdef MEM_CFG_LOCK_EN
  // lock bit itself is always writable so it can be cleared
  always_ff @(posedge clk) begin
    if (rst) lock <= 1'b0;
    else if (state == ACK && wr_q && addr_q == 8'h12) lock <= data_q[0];
  end
`endif
endmodule
